// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction scheduler: default field widths,
// opcode constants and the scheduler state encoding.
package cpu_pkg;

    localparam int OP_W  = 3;
    localparam int RA_W  = 5;
    localparam int INS_W = OP_W + 3 * RA_W;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SLL = 3'd6,
        OP_SRL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_e;

endpackage

// File: rtl/ins_sched_rr_arb2.sv
// Two-way round-robin arbiter. A tie goes to the requester that was not
// granted last; the pointer only moves when the caller reports a handshake.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_prio;

    // Pick the winner: a lone requester always wins, a tie goes to r_prio
    always_comb begin
        o_gnt = i_req;
        if (i_req[0] && i_req[1]) begin
            o_gnt = r_prio ? 2'b10 : 2'b01;
        end
    end

    // Hand priority to the other requester after each completed handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_advance) begin
            r_prio <= ~o_gnt[1];
        end
    end

endmodule

// File: rtl/ins_sched.sv
// Instruction scheduler: arbitrates two requesters onto one datapath issue
// port. Define INS_SCHED_HAZARD_EN to compile in the read-after-write
// interlock, which inserts a single bubble (state STALL) on a dependency.
import cpu_pkg::*;

module ins_sched #(
    parameter int OP_WIDTH  = OP_W,
    parameter int RA_WIDTH  = RA_W,
    parameter int INS_WIDTH = OP_WIDTH + 3 * RA_WIDTH,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [INS_WIDTH-1:0] req0_ins,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [INS_WIDTH-1:0] req1_ins,
    output logic                 req1_ready,
    output logic [INS_WIDTH-1:0] dp_ins,
    output logic                 dp_issue,
    output logic                 dp_src,
    output logic [CNT_WIDTH-1:0] issued_cnt
);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [INS_WIDTH-1:0]   r_dp_ins;
    logic                   r_dp_issue;
    logic                   r_dp_src;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic [1:0]             w_gnt;
    logic [INS_WIDTH-1:0]   w_cand_ins;
    logic                   w_dep;
    logic                   w_hazard;
    logic                   w_handshake;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     ({req1_valid, req0_valid}),
        .i_advance (w_handshake),
        .o_gnt     (w_gnt)
    );

    assign w_cand_ins = w_gnt[1] ? req1_ins : req0_ins;

`ifdef INS_SCHED_HAZARD_EN
    logic [OP_WIDTH-1:0] w_cand_op;
    logic [RA_WIDTH-1:0] w_cand_rs1;
    logic [RA_WIDTH-1:0] w_cand_rs2;
    logic [RA_WIDTH-1:0] w_dp_rdest;
    logic                w_is_shift;

    assign w_cand_op  = w_cand_ins[INS_WIDTH-1 -: OP_WIDTH];
    assign w_cand_rs1 = w_cand_ins[2*RA_WIDTH-1 -: RA_WIDTH];
    assign w_cand_rs2 = w_cand_ins[RA_WIDTH-1:0];
    assign w_dp_rdest = r_dp_ins[3*RA_WIDTH-1 -: RA_WIDTH];
    // rs2 of a shift is an immediate shift amount, not a register read
    assign w_is_shift = (w_cand_op == OP_WIDTH'(OP_SLL)) || (w_cand_op == OP_WIDTH'(OP_SRL));

    // Winner reads the register the instruction issued last cycle will write
    always_comb begin
        w_dep = (w_cand_rs1 == w_dp_rdest) || (!w_is_shift && (w_cand_rs2 == w_dp_rdest));
    end
`else
    assign w_dep = 1'b0;
`endif

    // Only an instruction issued in the previous cycle can still be in flight
    assign w_hazard    = (r_state == ISSUE) && w_dep && (req0_valid || req1_valid);
    assign req0_ready  = rst_n && w_gnt[0] && !w_hazard;
    assign req1_ready  = rst_n && w_gnt[1] && !w_hazard;
    assign w_handshake = req0_ready || req1_ready;

    // Next state: issue on a handshake, bubble on a blocked request, else idle
    always_comb begin
        w_state_next = IDLE;
        if (w_handshake) begin
            w_state_next = ISSUE;
        end else if (w_hazard) begin
            w_state_next = STALL;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the accepted instruction for the datapath and count issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_ins   <= '0;
            r_dp_issue <= 1'b0;
            r_dp_src   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_dp_issue <= w_handshake;
            if (w_handshake) begin
                r_dp_ins <= w_cand_ins;
                r_dp_src <= req1_ready;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign dp_ins     = r_dp_ins;
    assign dp_issue   = r_dp_issue;
    assign dp_src     = r_dp_src;
    assign issued_cnt = r_cnt;

endmodule

// File: tb/tb_ins_sched.sv
// Testbench for ins_sched: directed scenarios plus randomized traffic
// checked against a transaction-level model of the scheduling rules.
import cpu_pkg::*;

module tb_ins_sched;

`ifdef INS_SCHED_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [17:0] req0_ins;
    logic        req0_ready;
    logic        req1_valid;
    logic [17:0] req1_ins;
    logic        req1_ready;
    logic [17:0] dp_ins;
    logic        dp_issue;
    logic        dp_src;
    logic [15:0] issued_cnt;

    int vectors;
    int miscompares;

    ins_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ins   (req0_ins),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_ins   (req1_ins),
        .req1_ready (req1_ready),
        .dp_ins     (dp_ins),
        .dp_issue   (dp_issue),
        .dp_src     (dp_src),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [17:0] mk(input int op, input int rd, input int rs1, input int rs2);
        return 18'(op * 32768 + rd * 1024 + rs1 * 32 + rs2);
    endfunction

    task automatic drive(input bit v0, input logic [17:0] i0, input bit v1, input logic [17:0] i1);
        req0_valid = v0;
        req0_ins   = i0;
        req1_valid = v1;
        req1_ins   = i1;
    endtask

    // Leaves the bench at 1 time unit after a rising edge, out of reset
    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] i0;
        i0 = mk(0, 3, 1, 2);
        rst_n = 1'b0;
        drive(1'b1, i0, 1'b1, mk(1, 4, 1, 2));
        @(posedge clk);
        #1;
        vectors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        vectors++;
        if (dp_issue !== 1'b0 || dp_ins !== 18'h0 || dp_src !== 1'b0 || issued_cnt !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got issue=%b ins=%h src=%b cnt=%h expected all zero",
                     dp_issue, dp_ins, dp_src, issued_cnt);
        end
        rst_n = 1'b1;
        #2;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL first_grant: got %b%b expected 10", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (dp_issue !== 1'b1 || dp_ins !== i0 || dp_src !== 1'b0 || issued_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL first_issue: got issue=%b ins=%h src=%b cnt=%0d expected 1 %h 0 1",
                     dp_issue, dp_ins, dp_src, issued_cnt, i0);
        end
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_alternate();
        logic [17:0] i0;
        logic [17:0] i1;
        i0 = mk(0, 3, 1, 2);
        i1 = mk(1, 4, 1, 2);
        do_reset();
        drive(1'b1, i0, 1'b1, i1);
        for (int k = 0; k < 4; k++) begin
            #2;
            vectors++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                miscompares++;
                $display("[TB] FAIL alt_ready[%0d]: got %b%b expected %b%b",
                         k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (dp_issue !== 1'b1 || dp_src !== (k % 2 == 1) || dp_ins !== ((k % 2 == 1) ? i1 : i0)) begin
                miscompares++;
                $display("[TB] FAIL alt_issue[%0d]: got issue=%b src=%b ins=%h expected 1 %b %h",
                         k, dp_issue, dp_src, dp_ins, k % 2 == 1, (k % 2 == 1) ? i1 : i0);
            end
        end
        vectors++;
        if (issued_cnt !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL alt_count: got %0d expected 4", issued_cnt);
        end
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_hazard();
        logic [17:0] i_add;
        logic [17:0] i_xor;
        i_add = mk(0, 5, 1, 2);
        i_xor = mk(4, 6, 5, 3);
        do_reset();
        drive(1'b1, i_add, 1'b0, '0);
        @(posedge clk);
        #1;
        drive(1'b1, i_xor, 1'b0, '0);
        #2;
        vectors++;
        if (req0_ready !== !HAZ) begin
            miscompares++;
            $display("[TB] FAIL haz_ready: got %b expected %b", req0_ready, !HAZ);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (dp_issue !== !HAZ || dp_ins !== (HAZ ? i_add : i_xor)) begin
            miscompares++;
            $display("[TB] FAIL haz_bubble: got issue=%b ins=%h expected %b %h",
                     dp_issue, dp_ins, !HAZ, HAZ ? i_add : i_xor);
        end
`ifdef INS_SCHED_HAZARD_EN
        vectors++;
        if (dut.r_state !== STALL) begin
            miscompares++;
            $display("[TB] FAIL haz_state: got %0d expected %0d", dut.r_state, STALL);
        end
        #2;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL haz_release: got %b expected 1", req0_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (dp_issue !== 1'b1 || dp_ins !== i_xor) begin
            miscompares++;
            $display("[TB] FAIL haz_after: got issue=%b ins=%h expected 1 %h", dp_issue, dp_ins, i_xor);
        end
`endif
        vectors++;
        if (issued_cnt !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL haz_count: got %0d expected 2", issued_cnt);
        end
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_shift();
        logic [17:0] i_add;
        logic [17:0] i_sll;
        i_add = mk(0, 4, 1, 2);
        i_sll = mk(6, 7, 1, 4);
        do_reset();
        drive(1'b1, i_add, 1'b0, '0);
        @(posedge clk);
        #1;
        drive(1'b1, i_sll, 1'b0, '0);
        #2;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL shift_ready: got %b expected 1", req0_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (dp_issue !== 1'b1 || dp_ins !== i_sll) begin
            miscompares++;
            $display("[TB] FAIL shift_issue: got issue=%b ins=%h expected 1 %h", dp_issue, dp_ins, i_sll);
        end
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_random();
        int          prio;
        int          prev_rd;
        int          cnt;
        int          win;
        bit          prev_iss;
        bit          haz;
        bit          v0;
        bit          v1;
        bit          exp_r0;
        bit          exp_r1;
        bit          exp_src;
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] cand;
        logic [17:0] exp_ins;
        int          c_op;
        int          c_rd;
        int          c_rs1;
        int          c_rs2;
        do_reset();
        prio     = 0;
        prev_iss = 1'b0;
        prev_rd  = 0;
        cnt      = 0;
        exp_ins  = '0;
        exp_src  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            v0 = ($urandom % 4) != 0;
            v1 = ($urandom % 4) != 0;
            a  = mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            b  = mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            drive(v0, a, v1, b);
            if (v0 && v1) win = prio;
            else if (v0)  win = 0;
            else if (v1)  win = 1;
            else          win = -1;
            cand  = (win == 1) ? b : a;
            c_op  = int'(cand) / 32768;
            c_rd  = (int'(cand) / 1024) % 32;
            c_rs1 = (int'(cand) / 32) % 32;
            c_rs2 = int'(cand) % 32;
            haz = HAZ && (win >= 0) && prev_iss &&
                  ((c_rs1 == prev_rd) || ((c_op != 6) && (c_op != 7) && (c_rs2 == prev_rd)));
            exp_r0 = (win == 0) && !haz;
            exp_r1 = (win == 1) && !haz;
            #2;
            vectors++;
            if (req0_ready !== exp_r0 || req1_ready !== exp_r1) begin
                miscompares++;
                $display("[TB] FAIL rand_ready[%0d]: got %b%b expected %b%b",
                         n, req0_ready, req1_ready, exp_r0, exp_r1);
            end
            @(posedge clk);
            #1;
            if (exp_r0 || exp_r1) begin
                prev_iss = 1'b1;
                prev_rd  = c_rd;
                exp_ins  = cand;
                exp_src  = (win == 1);
                prio     = 1 - win;
                cnt      = (cnt + 1) % 65536;
            end else begin
                prev_iss = 1'b0;
            end
            vectors++;
            if (dp_issue !== (exp_r0 || exp_r1) || dp_ins !== exp_ins || dp_src !== exp_src ||
                issued_cnt !== 16'(cnt)) begin
                miscompares++;
                $display("[TB] FAIL rand_out[%0d]: got issue=%b ins=%h src=%b cnt=%0d expected %b %h %b %0d",
                         n, dp_issue, dp_ins, dp_src, issued_cnt, exp_r0 || exp_r1, exp_ins, exp_src, cnt);
            end
        end
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset_midop();
        do_reset();
        drive(1'b1, mk(0, 3, 1, 2), 1'b0, '0);
        @(posedge clk);
        #1;
        vectors++;
        if (dp_issue !== 1'b1 || issued_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL mid_pre: got issue=%b cnt=%0d expected 1 1", dp_issue, issued_cnt);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dp_issue !== 1'b0 || issued_cnt !== 16'd0 || dp_ins !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_async: got issue=%b cnt=%0d ins=%h expected 0 0 0",
                     dp_issue, issued_cnt, dp_ins);
        end
        drive(1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (dp_issue !== 1'b0 || issued_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_noreissue: got issue=%b cnt=%0d expected 0 0", dp_issue, issued_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, mk(0, 3, 1, 2), 1'b0, '0);
        repeat (65535) @(posedge clk);
        #1;
        vectors++;
        if (issued_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL wrap_full: got %h expected ffff", issued_cnt);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (issued_cnt !== 16'h0000 || dp_issue !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_zero: got cnt=%h issue=%b expected 0000 1", issued_cnt, dp_issue);
        end
        drive(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        test_reset();
        test_alternate();
        test_hazard();
        test_shift();
        test_random();
        test_reset_midop();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ins_sched.md
INS_SCHED -- requirements
Module: ins_sched

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 3, opcode field width.
REQ-002 SHALL have parameter RA_WIDTH, default 5, register-address field width.
REQ-003 SHALL have parameter INS_WIDTH, default OP_WIDTH+3*RA_WIDTH (18), instruction width; field layout is op, rdest, rs1, rs2 from MSB down.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, issue-counter width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req0_valid, input, 1, requester 0 offers an instruction.
REQ-008 SHALL have port req0_ins, input, INS_WIDTH, requester 0 instruction.
REQ-009 SHALL have port req0_ready, output, 1, requester 0 instruction accepted this cycle.
REQ-010 SHALL have ports req1_valid, req1_ins and req1_ready with the same directions, widths and meanings as the requester 0 ports.
REQ-011 SHALL have port dp_ins, output, INS_WIDTH, instruction presented to the datapath.
REQ-012 SHALL have port dp_issue, output, 1, dp_ins is valid this cycle; the datapath gates its register write with it.
REQ-013 SHALL have port dp_src, output, 1, requester index of the current dp_ins.
REQ-014 SHALL have port issued_cnt, output, CNT_WIDTH, count of issued instructions.

Function
REQ-015 SHALL complete a handshake on requester n in a cycle where reqn_valid and reqn_ready are both high.
REQ-016 SHALL derive reqn_ready combinationally from reqn_valid, the grant and the stall condition; at most one ready SHALL be high per cycle.
REQ-017 SHALL arbitrate round-robin: when both requesters are valid, the one not granted last wins; after reset requester 0 has priority.
REQ-018 SHALL, on a handshake, register dp_ins<=reqn_ins, dp_src<=n and dp_issue<=1 at the same edge, giving a latency of 1 cycle from handshake to dp_issue.
REQ-019 SHALL register dp_issue<=0 in any cycle with no handshake, and SHALL then hold dp_ins and dp_src at their previous values.
REQ-020 SHALL implement states IDLE (nothing issued last cycle), ISSUE (issued last cycle) and STALL (bubble inserted).
REQ-021 SHALL transition to ISSUE on a handshake, to STALL when a hazard blocks a valid request, and to IDLE otherwise.
REQ-022 SHALL define a hazard as: state is ISSUE, and the candidate's rs1, or its rs2 when its opcode is not SLL/SRL, equals the rdest of dp_ins.
REQ-023 SHALL force all readys low for exactly one cycle on a hazard; from STALL the next cycle SHALL be hazard-free, and the round-robin pointer SHALL not advance during the stall.
REQ-024 SHALL ignore the rs2 field of SLL/SRL for hazard purposes, because that field is a shift amount.
REQ-025 SHALL increment issued_cnt by 1 per handshake, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-026 SHALL apply the hazard check to whichever request wins arbitration; the other requester SHALL wait even if it is hazard-free.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force state=IDLE, dp_issue=0, dp_ins=0, dp_src=0, issued_cnt=0, the round-robin pointer to requester 0, and all readys to 0.
REQ-028 SHALL, on reset mid-operation, discard any in-flight instruction without issuing it.
REQ-029 SHALL treat the first rising edge after rst_n deasserts as a normal arbitration cycle.

Configuration
REQ-030 SHALL compile in hazard interlock (REQ-022 to REQ-024, state STALL) when INS_SCHED_HAZARD_EN is defined.
REQ-031 SHALL, when INS_SCHED_HAZARD_EN is undefined, never enter STALL and issue back-to-back regardless of register dependencies.

Structure
REQ-032 SHALL place the opcode constants (ADD..SRL), the default field widths and the state encoding in the shared package cpu_pkg.
REQ-033 SHALL implement the two-way round-robin grant logic as sub-module rr_arb2.

Verification
REQ-034 SHALL verify: reset with both valid, req0=ADD r3,r1,r2 -> req0_ready=1 in the first cycle, then dp_issue=1, dp_ins=req0_ins, dp_src=0, issued_cnt=1.
REQ-035 SHALL verify: both valid and independent for 4 cycles -> grants alternate 0,1,0,1 and issued_cnt=4.
REQ-036 SHALL verify: ADD r5,r1,r2, then XOR r6,r5,r3 with the hazard macro defined -> one cycle with dp_issue=0 and state STALL, then XOR issued; with the macro undefined -> no bubble.
REQ-037 SHALL verify: ADD r4,r1,r2, then SLL r7,r1,4 (shamt 4 equals r4) -> no stall.
REQ-038 SHALL verify: issued_cnt preset to 0xFFFF, then one issue -> issued_cnt=0.
REQ-039 SHALL verify: rst_n low in the cycle after a handshake -> dp_issue=0 immediately, issued_cnt=0, and the instruction is not reissued.
